// File: rtl/neptuno_joystick_reader.sv
// rtl/neptuno_joystick_reader.sv - Neptuno 2x8-bit joystick shift-chain reader with Megadrive P7 scanning
module neptuno_joystick_reader #(
    parameter int CLK_DIV   = 16,
    parameter int GAP_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       joy_data,
    output logic       joy_clk,
    output logic       joy_load,
    output logic       joy_p7,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic       valid
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(GAP_TICKS + 1);

    typedef enum logic [1:0] {
        S_GAP   = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_END   = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic [GAP_W-1:0] gap_cnt, gap_next;
    logic             load_cnt, load_cnt_next;
    logic [3:0]       idx, idx_next;
    logic [1:0]       sync;
    logic [15:0]      shift, shift_next;
    logic [15:0]      cap_p1, cap_p1_next;
    logic             joy_clk_next, joy_load_next, joy_p7_next, valid_next;
    logic [7:0]       joy1_next, joy2_next;
    logic             gap_done;

    assign tick     = (div == DIV_W'(CLK_DIV - 1));
    assign gap_done = (gap_cnt == GAP_W'(GAP_TICKS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_GAP;
            div      <= '0;
            gap_cnt  <= '0;
            load_cnt <= 1'b0;
            idx      <= 4'd0;
            sync     <= 2'b00;
            shift    <= '0;
            cap_p1   <= '0;
            joy_clk  <= 1'b0;
            joy_load <= 1'b1;
            joy_p7   <= 1'b1;
            joy1     <= 8'h00;
            joy2     <= 8'h00;
            valid    <= 1'b0;
        end else begin
            state    <= state_next;
            div      <= tick ? '0 : div + DIV_W'(1);
            gap_cnt  <= gap_next;
            load_cnt <= load_cnt_next;
            idx      <= idx_next;
            sync     <= {sync[0], joy_data};
            shift    <= shift_next;
            cap_p1   <= cap_p1_next;
            joy_clk  <= joy_clk_next;
            joy_load <= joy_load_next;
            joy_p7   <= joy_p7_next;
            joy1     <= joy1_next;
            joy2     <= joy2_next;
            valid    <= valid_next;
        end
    end

    // Within SHIFT the registered joy_clk level tells tick A (low) from tick B (high).
    always_comb begin
        state_next    = state;
        gap_next      = gap_cnt;
        load_cnt_next = load_cnt;
        idx_next      = idx;
        if (tick) begin
            case (state)
                S_GAP: begin
                    if (gap_done) begin
                        state_next    = S_LOAD;
                        gap_next      = '0;
                        load_cnt_next = 1'b0;
                    end else begin
                        gap_next = gap_cnt + GAP_W'(1);
                    end
                end
                S_LOAD: begin
                    if (load_cnt) begin
                        state_next = S_SHIFT;
                        idx_next   = 4'd0;
                    end else begin
                        load_cnt_next = 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (joy_clk) begin
                        idx_next = idx + 4'd1;
                        if (idx == 4'd15) state_next = S_END;
                    end
                end
                S_END: begin
                    // The evaluation tick also counts as the first tick of the gap.
                    state_next = S_GAP;
                    gap_next   = GAP_W'(1);
                end
                default: state_next = S_GAP;
            endcase
        end
    end

    always_comb begin
        joy_clk_next  = joy_clk;
        joy_load_next = joy_load;
        joy_p7_next   = joy_p7;
        shift_next    = shift;
        cap_p1_next   = cap_p1;
        joy1_next     = joy1;
        joy2_next     = joy2;
        valid_next    = 1'b0;
        if (tick) begin
            case (state)
                S_GAP: begin
                    if (gap_done) joy_load_next = 1'b0;
                end
                S_LOAD: begin
                    if (load_cnt) joy_load_next = 1'b1;
                end
                S_SHIFT: begin
                    if (!joy_clk) begin
                        shift_next[idx] = sync[1];
                        joy_clk_next    = 1'b1;
                    end else begin
                        joy_clk_next = 1'b0;
                    end
                end
                S_END: begin
                    if (joy_p7) begin
                        cap_p1_next = shift;
                        joy_p7_next = 1'b0;
                    end else begin
                        joy1_next   = ~{shift[5], shift[4], cap_p1[5], cap_p1[4], cap_p1[3:0]};
                        joy2_next   = ~{shift[13], shift[12], cap_p1[13], cap_p1[12], cap_p1[11:8]};
                        valid_next  = 1'b1;
                        joy_p7_next = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neptuno_joystick_reader.sv
// tb/tb_neptuno_joystick_reader.sv - self-checking bench for neptuno_joystick_reader
module tb_neptuno_joystick_reader;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       joy_data;
    logic       joy_clk, joy_load, joy_p7, valid;
    logic [7:0] joy1, joy2;

    logic        drive_raw = 1'b1;
    logic        raw_val = 1'b0;
    logic [15:0] pat_p1 = 16'hFFFF;
    logic [15:0] pat_p0 = 16'hFFFF;
    logic [15:0] chain = 16'hFFFF;
    logic        prev_jclk = 1'b0;

    int checks = 0;
    int errors = 0;
    int hold_bad = 0;

    typedef struct {
        logic [15:0] p1;
        logic [15:0] p0;
        logic [7:0]  e1;
        logic [7:0]  e2;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    assign joy_data = drive_raw ? raw_val : chain[0];

    // Two 74HC165s: parallel load while load is low, shift toward index 0 on joy_clk rise.
    always @(posedge clk) begin
        prev_jclk <= joy_clk;
        if (!joy_load)
            chain <= joy_p7 ? pat_p1 : pat_p0;
        else if (joy_clk && !prev_jclk)
            chain <= {1'b1, chain[15:1]};
    end

    neptuno_joystick_reader #(.CLK_DIV(16), .GAP_TICKS(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .joy_data (joy_data),
        .joy_clk  (joy_clk),
        .joy_load (joy_load),
        .joy_p7   (joy_p7),
        .joy1     (joy1),
        .joy2     (joy2),
        .valid    (valid)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Wire image of one pad given pressed buttons {Start,A,C,B,up,down,left,right}.
    function automatic logic [7:0] pad_p1(input logic [7:0] pr, input logic [1:0] junk);
        return {junk, ~pr[5], ~pr[4], ~pr[3:0]};
    endfunction

    function automatic logic [7:0] pad_p0(input logic [7:0] pr, input logic [5:0] junk);
        return {junk[5:4], ~pr[7], ~pr[6], junk[3:0]};
    endfunction

    task automatic wait_valid(input string name);
        int n;
        logic [7:0] h1, h2;
        logic ok;
        n = 0;
        ok = 1'b0;
        h1 = joy1;
        h2 = joy2;
        while (n < 1500) begin
            step();
            n++;
            if (valid) begin
                ok = 1'b1;
                break;
            end
            if (joy1 !== h1 || joy2 !== h2) hold_bad++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no valid within %0d clocks", name, n);
        end
    endtask

    initial begin
        int n, m, k, c, rises, run, minrun, maxrun, p7ch, p7bad, clkbad, nv, loads;
        logic pclk, pp7, pload;
        logic [7:0] pr1, pr2;

        vecs[0] = '{16'hFFFF, 16'hFFFF, 8'h00, 8'h00};
        vecs[1] = '{16'hFFE7, 16'hFFFF, 8'h18, 8'h00};
        vecs[2] = '{16'hFFFF, 16'hDFEF, 8'h40, 8'h80};
        vecs[3] = '{16'hC0C0, 16'hC0C0, 8'hFF, 8'hFF};
        vecs[4] = '{16'h3F3F, 16'h3F3F, 8'h00, 8'h00};

        reset_n = 1'b0;
        drive_raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            raw_val = ~raw_val;
            step();
        end
        chk("rst_joy_clk", 32'(joy_clk), 32'd0);
        chk("rst_joy_load", 32'(joy_load), 32'd1);
        chk("rst_joy_p7", 32'(joy_p7), 32'd1);
        chk("rst_joy1", 32'(joy1), 32'd0);
        chk("rst_joy2", 32'(joy2), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);

        @(negedge clk);
        reset_n = 1'b1;
        drive_raw = 1'b0;

        n = 0;
        while (joy_load === 1'b1 && n < 400) begin
            step();
            n++;
        end
        chk("first_load_fall", 32'(n), 32'd144);

        m = 0;
        clkbad = 0;
        while (joy_load === 1'b0 && m < 100) begin
            if (joy_clk) clkbad++;
            step();
            m++;
        end
        chk("load_low_len", 32'(m), 32'd32);
        chk("clk_during_load", 32'(clkbad), 32'd0);

        rises = 0; run = 0; minrun = 999; maxrun = 0; p7ch = 0; p7bad = 0; k = 0;
        pclk = joy_clk;
        pp7 = joy_p7;
        while (joy_load === 1'b1 && k < 1000) begin
            step();
            k++;
            if (joy_clk && !pclk) rises++;
            if (joy_clk) run++;
            else if (pclk) begin
                if (run < minrun) minrun = run;
                if (run > maxrun) maxrun = run;
                run = 0;
            end
            if (joy_p7 !== pp7) begin
                p7ch++;
                if (rises != 16 || joy_clk || !joy_load) p7bad++;
            end
            pclk = joy_clk;
            pp7 = joy_p7;
        end
        chk("clk_rises", 32'(rises), 32'd16);
        chk("clk_high_min", 32'(minrun), 32'd16);
        chk("clk_high_max", 32'(maxrun), 32'd16);
        chk("p7_changes", 32'(p7ch), 32'd1);
        chk("p7_illegal", 32'(p7bad), 32'd0);
        chk("p7_after_p1", 32'(joy_p7), 32'd0);
        chk("phase_period", 32'(m + k), 32'd688);

        c = n + m + k;
        while (!valid && c < 3000) begin
            step();
            c++;
        end
        chk("first_valid_window", 32'(c >= 1376 && c <= 1392), 32'd1);
        chk("idle_joy1", 32'(joy1), 32'd0);
        chk("idle_joy2", 32'(joy2), 32'd0);
        step();
        chk("valid_width", 32'(valid), 32'd0);
        c = 1;
        while (!valid && c < 3000) begin
            step();
            c++;
        end
        chk("valid_period", 32'(c), 32'd1376);

        for (int i = 0; i < 5; i++) begin
            pat_p1 = vecs[i].p1;
            pat_p0 = vecs[i].p0;
            wait_valid($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_joy1", i), 32'(joy1), 32'(vecs[i].e1));
            chk($sformatf("vec%0d_joy2", i), 32'(joy2), 32'(vecs[i].e2));
        end

        for (int i = 0; i < 20; i++) begin
            pr1 = 8'($urandom);
            pr2 = 8'($urandom);
            pat_p1 = {pad_p1(pr2, 2'($urandom)), pad_p1(pr1, 2'($urandom))};
            pat_p0 = {pad_p0(pr2, 6'($urandom)), pad_p0(pr1, 6'($urandom))};
            wait_valid($sformatf("rnd%0d", i));
            chk($sformatf("rnd%0d_joy1", i), 32'(joy1), 32'(pr1));
            chk($sformatf("rnd%0d_joy2", i), 32'(joy2), 32'(pr2));
        end

        pat_p1 = 16'hFFE7;
        pat_p0 = 16'hDFEF;
        wait_valid("pre_reset");
        chk("pre_reset_joy1", 32'(joy1), 32'h58);
        chk("pre_reset_joy2", 32'(joy2), 32'h80);
        chk("hold_between_valid", 32'(hold_bad), 32'd0);

        // Walk into the P0 phase and stop at the rising edge of bit 9.
        loads = 0; k = 0;
        pload = joy_load;
        while (loads < 2 && k < 3000) begin
            step();
            k++;
            if (!joy_load && pload) loads++;
            pload = joy_load;
        end
        rises = 0;
        pclk = joy_clk;
        while (rises < 10 && k < 3000) begin
            step();
            k++;
            if (joy_clk && !pclk) rises++;
            pclk = joy_clk;
        end
        chk("reached_p0_bit9", 32'(joy_p7 == 1'b0 && rises == 10), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_joy1", 32'(joy1), 32'd0);
        chk("midrst_joy2", 32'(joy2), 32'd0);
        chk("midrst_joy_clk", 32'(joy_clk), 32'd0);
        chk("midrst_joy_load", 32'(joy_load), 32'd1);
        chk("midrst_joy_p7", 32'(joy_p7), 32'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        nv = 0;
        for (int i = 0; i < 1376; i++) begin
            step();
            if (valid) nv++;
        end
        chk("no_valid_after_rst", 32'(nv), 32'd0);
        chk("post_rst_hold_joy1", 32'(joy1), 32'd0);
        wait_valid("post_reset");
        chk("post_reset_joy1", 32'(joy1), 32'h58);
        chk("post_reset_joy2", 32'(joy2), 32'h80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
